pipereg_elastic: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH stages, each WIDTH bits wide, with a per-stage valid bit, valid/ready handshake on both sides, bubble collapsing and a synchronous flush. It replaces the fixed single-stage reset/clear pipeline registers between CPU pipeline stages. Stalls propagate backward through the ready chain instead of through a global enable. Hazard/flush logic drives `flush` exactly as it drives clear on the single-stage register today.

---
 rtl/pipereg_elastic.sv | 105 ++++++++++
 tb/tb_pipereg_elastic.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipereg_elastic.sv
// Elastic multi-stage pipeline register with valid/ready handshake,
// bubble collapsing, synchronous flush and registered occupancy count.
//
// Ports: clk, reset (async, active-low), flush (sync clear),
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//   (downstream), occupancy (number of valid stages, 0..DEPTH).
module pipereg_elastic #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CNTW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  occupancy
);

  localparam logic [DEPTH-1:0] ONES = '1;

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH:0]   vin;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_d   [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [CNTW-1:0]  occ_q, occ_d;
  logic             in_xfer;
  logic             out_xfer;

  // adv[i] is low only when stages i..DEPTH-1 are all full and the
  // output is stalled; written flat to avoid a self-referencing chain.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = out_ready | ~&(v_q | ~(ONES << i));
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v_q[DEPTH-1] & out_ready & ~flush;

  assign vin   = {v_q, in_valid};
  assign src_v = vin[DEPTH-1:0];

  always_comb begin
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
      if (flush) begin
        v_d[i] = 1'b0;
        d_d[i] = RESET_VALUE;
      end else if (adv[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) d_d[i] = src_d[i];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      flush:                occ_d = '0;
      in_xfer & ~out_xfer:  occ_d = occ_q + CNTW'(1);
      out_xfer & ~in_xfer:  occ_d = occ_q - CNTW'(1);
      default:              occ_d = occ_q;
    endcase
  end

  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_VALUE;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipereg_elastic.sv
// Directed bench for pipereg_elastic: a DEPTH=3 instance for streaming,
// backpressure, flush and reset, plus a DEPTH=1 instance.
module tb_pipereg_elastic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         errors = 0;
  int         checks = 0;

  logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [7:0] a_in_data = 0;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;

  logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0] b_in_data = 0;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [0:0] b_occ;

  always #5 clk = ~clk;

  pipereg_elastic #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .occupancy(a_occ)
  );

  pipereg_elastic #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h5A)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occ)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_a_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++;
      $display("FAIL rst_a_data got=%h exp=00", a_out_data); end
    checks++; if (a_occ !== 2'd0) begin errors++;
      $display("FAIL rst_a_occ got=%0d exp=0", a_occ); end
    checks++; if (a_in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_a_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (b_out_data !== 8'h5A) begin errors++;
      $display("FAIL rst_b_data got=%h exp=5a", b_out_data); end
    checks++; if (b_out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_b_valid got=%0b exp=0", b_out_valid); end
    #8 reset = 1'b1;
    tick();
  endtask

  task automatic test_streaming;
    int ev, eo;
    a_out_ready = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      a_in_valid = (k <= 16);
      a_in_data  = 8'(k);
      tick();
      ev = (k >= 3 && k <= 18) ? 1 : 0;
      eo = (k < 3) ? k : (k <= 16) ? 3 : 19 - k;
      checks++; if (a_out_valid !== 1'(ev)) begin errors++;
        $display("FAIL stream_valid k=%0d got=%0b exp=%0d", k, a_out_valid, ev); end
      if (ev == 1) begin
        checks++; if (a_out_data !== 8'(k-2)) begin errors++;
          $display("FAIL stream_data k=%0d got=%h exp=%h", k, a_out_data, 8'(k-2)); end
      end
      checks++; if (a_occ !== 2'(eo)) begin errors++;
        $display("FAIL stream_occ k=%0d got=%0d exp=%0d", k, a_occ, eo); end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA1; tick();
    a_in_valid = 1'b0; tick();
    a_in_valid = 1'b1; a_in_data = 8'hA2; tick();
    a_in_valid = 1'b0; tick();
    checks++; if (a_occ !== 2'd2) begin errors++;
      $display("FAIL bp_occ2 got=%0d exp=2", a_occ); end
    checks++; if (a_in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_ready2 got=%0b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA1) begin errors++;
      $display("FAIL bp_head got=%0b/%h exp=1/a1", a_out_valid, a_out_data); end
    a_in_valid = 1'b1; a_in_data = 8'hA3; tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_full_ready got=%0b exp=0", a_in_ready); end
    checks++; if (a_occ !== 2'd3) begin errors++;
      $display("FAIL bp_occ3 got=%0d exp=3", a_occ); end
    a_in_data = 8'hEE; tick();
    checks++; if (a_occ !== 2'd3 || a_out_data !== 8'hA1) begin errors++;
      $display("FAIL bp_drop got=%0d/%h exp=3/a1", a_occ, a_out_data); end
  endtask

  task automatic test_full_simul;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hA3; exp_q[1] = 8'hB0; exp_q[2] = 8'h00;
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'hB0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++;
      $display("FAIL full_ready got=%0b exp=1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_occ !== 2'd3 || a_out_data !== 8'hA2) begin errors++;
      $display("FAIL full_swap got=%0d/%h exp=3/a2", a_occ, a_out_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_occ !== 2'(2-k)) begin errors++;
        $display("FAIL full_drain_occ k=%0d got=%0d exp=%0d", k, a_occ, 2-k); end
      if (k < 2) begin
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_q[k]) begin errors++;
          $display("FAIL full_drain k=%0d got=%0b/%h exp=1/%h", k, a_out_valid, a_out_data, exp_q[k]); end
      end else begin
        checks++; if (a_out_valid !== 1'b0) begin errors++;
          $display("FAIL full_empty got=%0b exp=0", a_out_valid); end
      end
    end
  endtask

  task automatic test_flush;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hC1; tick();
    a_in_data = 8'hC2; tick();
    checks++; if (a_occ !== 2'd2) begin errors++;
      $display("FAIL fl_pre_occ got=%0d exp=2", a_occ); end
    a_flush = 1'b1; a_in_data = 8'hCC; a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++;
      $display("FAIL fl_in_ready got=%0b exp=0", a_in_ready); end
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 8'h00) begin errors++;
      $display("FAIL fl_after got=%0b/%0d/%h exp=0/0/00", a_out_valid, a_occ, a_out_data); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++;
        $display("FAIL fl_ghost k=%0d got=%0b/%h exp=0", k, a_out_valid, a_out_data); end
    end
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hD1; tick();
    a_in_data = 8'hD2; tick();
    a_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00) begin errors++;
      $display("FAIL rm_out got=%0b/%h exp=0/00", a_out_valid, a_out_data); end
    checks++; if (a_occ !== 2'd0 || a_in_ready !== 1'b1) begin errors++;
      $display("FAIL rm_occ got=%0d/%0b exp=0/1", a_occ, a_in_ready); end
    reset = 1'b1;
    tick();
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin errors++;
      $display("FAIL rm_hold got=%0b/%0d exp=0/0", a_out_valid, a_occ); end
  endtask

  task automatic test_depth1;
    // {flush, in_valid, in_data, out_ready, exp_in_ready, exp_valid, exp_data}
    logic [20:0] vec [9];
    logic [20:0] e;
    vec[0] = {1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
    vec[1] = {1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
    vec[2] = {1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22};
    vec[3] = {1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 8'h22};
    vec[4] = {1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 8'h22};
    vec[5] = {1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44};
    vec[6] = {1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h44};
    vec[7] = {1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 8'h44};
    vec[8] = {1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h5A};
    for (int k = 0; k < 9; k++) begin
      e = vec[k];
      b_flush = e[20]; b_in_valid = e[19]; b_in_data = e[18:11];
      b_out_ready = e[10];
      #1;
      checks++; if (b_in_ready !== e[9]) begin errors++;
        $display("FAIL d1_ready k=%0d got=%0b exp=%0b", k, b_in_ready, e[9]); end
      tick();
      checks++; if (b_out_valid !== e[8] || b_occ !== e[8]) begin errors++;
        $display("FAIL d1_valid k=%0d got=%0b/%0d exp=%0b", k, b_out_valid, b_occ, e[8]); end
      checks++; if (b_out_data !== e[7:0]) begin errors++;
        $display("FAIL d1_data k=%0d got=%h exp=%h", k, b_out_data, e[7:0]); end
    end
    b_flush = 1'b0; b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_simul();
    test_flush();
    test_reset_mid();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
